// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the TX feeder launch-state encoding.
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_DONE = 1'b1
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and a sticky overflow flag.
// Meant to be reused as the RX FIFO feeding uart_rx fifo_full.
module sync_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH  = 16,
  parameter  int unsigned WIDTH  = DATA_W,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              pop,
  input  logic              clear_flags,
  output logic [WIDTH-1:0]  rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // Status comes from the registered count only, never from pointer compare.
  assign full    = (count == (ADDR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = wr_en && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Set has priority over clear when both happen in one cycle.
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (clear_flags) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch controller presenting one byte at a time to uart_tx,
// pacing launches on tx_done_tick and the tx_enable flow-control input.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              tx_enable,
  input  logic              clear_flags,
  input  logic              tx_done_tick,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  output logic              tx_busy,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  tx_state_e         state_q, state_d;
  logic              tx_start_d;
  logic [DATA_W-1:0] tx_data_d;
  logic [DATA_W-1:0] rd_data;
  logic              pop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .pop         (pop),
    .clear_flags (clear_flags),
    .rd_data     (rd_data),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow)
  );

  assign tx_busy = (state_q == WAIT_DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      state_q  <= state_d;
      tx_start <= tx_start_d;
      tx_data  <= tx_data_d;
    end
  end

  // tx_start defaults low, so the launch pulse lasts exactly one cycle.
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && tx_enable) begin
          pop        = 1'b1;
          tx_start_d = 1'b1;
          tx_data_d  = rd_data;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_done_tick) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed self-checking bench for uart_tx_feeder; the bench plays uart_tx.
module tb_uart_tx_feeder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       tx_enable = 1'b0;
  logic       clear_flags = 1'b0;
  logic       tx_done_tick = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;

  int unsigned checks = 0;
  int unsigned errors = 0;

  uart_tx_feeder #(.DEPTH(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .tx_enable    (tx_enable),
    .clear_flags  (clear_flags),
    .tx_done_tick (tx_done_tick),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    wr_en = 0; tx_enable = 0; clear_flags = 0; tx_done_tick = 0;
    #2 reset = 1;
    tick();
    #2 reset = 0;
    tick();
  endtask

  task automatic test_reset();
    #3;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rst_count got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full got %b want 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b want 0", overflow); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_start got %b want 0", tx_start); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rst_tx_busy got %b want 0", tx_busy); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
    reset = 0;
    tick();
  endtask

  task automatic test_single_byte();
    tx_enable = 1; wr_en = 1; wr_data = 8'hA5;
    tick();
    wr_en = 0;
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_no_bypass got %b want 0", tx_start); end
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count1 got %0d want 1", count); end
    tick();
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start got %b want 1", tx_start); end
    checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", tx_data); end
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", tx_busy); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_after_pop got %b want 1", empty); end
    tick();
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_pulse_width got %b want 0", tx_start); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL single_busy_hold got %b want 1", tx_busy); end
    end
    tx_done_tick = 1;
    tick();
    tx_done_tick = 0;
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL single_busy_clear got %b want 0", tx_busy); end
    tick();
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_no_relaunch got %b want 0", tx_start); end
    checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_data_hold got %h want a5", tx_data); end
    tx_done_tick = 1;
    tick();
    tx_done_tick = 0;
    checks++; if (tx_busy !== 1'b0 || tx_start !== 1'b0) begin errors++; $display("FAIL single_idle_done_ignored got busy=%b start=%b want 0 0", tx_busy, tx_start); end
  endtask

  task automatic test_burst();
    int unsigned nxt_push = 0;
    int unsigned nxt_exp = 0;
    int unsigned timer = 0;
    bit in_flight = 0;
    bit expect_launch = 0;
    bit done_now;
    logic [4:0] exp_cnt;
    int cyc = 0;
    tx_enable = 1;
    while (!(nxt_exp == 16 && !in_flight) && cyc < 400) begin
      wr_en = (nxt_push < 16);
      wr_data = 8'(nxt_push + 1);
      tx_done_tick = in_flight && (timer == 0);
      done_now = tx_done_tick;
      tick();
      if (wr_en) nxt_push++;
      if (expect_launch) begin
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL burst_launch_gap cyc %0d got %b want 1", cyc, tx_start); end
        expect_launch = 0;
      end
      if (tx_start === 1'b1) begin
        checks++; if (tx_data !== 8'(nxt_exp + 1)) begin errors++; $display("FAIL burst_order got %h want %h", tx_data, 8'(nxt_exp + 1)); end
        nxt_exp++;
        in_flight = 1;
        timer = 3;
      end else if (done_now) begin
        in_flight = 0;
        if (nxt_exp < 16) expect_launch = 1;
      end else if (in_flight) begin
        timer--;
      end
      exp_cnt = 5'(nxt_push - nxt_exp);
      checks++; if (count !== exp_cnt) begin errors++; $display("FAIL burst_count cyc %0d got %0d want %0d", cyc, count, exp_cnt); end
      cyc++;
    end
    wr_en = 0;
    tx_done_tick = 0;
    checks++; if (cyc >= 400) begin errors++; $display("FAIL burst_timeout got %0d sent want 16", nxt_exp); end
    checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL burst_final got count=%0d empty=%b want 0 1", count, empty); end
    checks++; if (tx_data !== 8'h10) begin errors++; $display("FAIL burst_last_data got %h want 10", tx_data); end
    tick();
  endtask

  task automatic test_overflow();
    tx_enable = 0;
    for (int i = 0; i < 17; i++) begin
      wr_en = 1; wr_data = 8'(8'h20 + i);
      tick();
      if (i == 15) begin
        checks++; if (full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_at_16 got full=%b ovf=%b want 1 0", full, overflow); end
      end
    end
    wr_en = 0;
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d want 16", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL ovf_no_launch got %b want 0", tx_start); end
    clear_flags = 1;
    tick();
    clear_flags = 0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
    wr_en = 1; wr_data = 8'hEE; clear_flags = 1;
    tick();
    wr_en = 0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b want 1", overflow); end
    tick();
    clear_flags = 0;
    checks++; if (overflow !== 1'b0 || count !== 5'd16) begin errors++; $display("FAIL ovf_reclear got ovf=%b count=%0d want 0 16", overflow, count); end
    tx_enable = 1;
    tick();
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'h20) begin errors++; $display("FAIL ovf_drain0 got start=%b data=%h want 1 20", tx_start, tx_data); end
    for (int i = 1; i < 17; i++) begin
      tick();
      checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL ovf_pulse got %b want 0", tx_start); end
      tick();
      tx_done_tick = 1;
      tick();
      tx_done_tick = 0;
      tick();
      if (i < 16) begin
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'(8'h20 + i)) begin errors++; $display("FAIL ovf_drain got start=%b data=%h want 1 %h", tx_start, tx_data, 8'(8'h20 + i)); end
      end else begin
        checks++; if (tx_start !== 1'b0 || tx_data !== 8'h2F || empty !== 1'b1) begin errors++; $display("FAIL ovf_no_30 got start=%b data=%h empty=%b want 0 2f 1", tx_start, tx_data, empty); end
      end
    end
  endtask

  task automatic test_wrap();
    tx_enable = 0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1; wr_data = 8'(8'h40 + i);
      tick();
    end
    wr_en = 0;
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL wrap_prefill got %0d want 3", count); end
    for (int i = 0; i < 40; i++) begin
      tx_enable = 1; wr_en = 1; wr_data = 8'(8'h43 + i);
      tick();
      tx_enable = 0; wr_en = 0;
      checks++; if (count !== 5'd3) begin errors++; $display("FAIL wrap_count i %0d got %0d want 3", i, count); end
      checks++; if (tx_start !== 1'b1 || tx_data !== 8'(8'h40 + i)) begin errors++; $display("FAIL wrap_data i %0d got start=%b data=%h want 1 %h", i, tx_start, tx_data, 8'(8'h40 + i)); end
      tick();
      tx_done_tick = 1;
      tick();
      tx_done_tick = 0;
    end
    tx_enable = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (tx_start !== 1'b1 || tx_data !== 8'(8'h68 + i)) begin errors++; $display("FAIL wrap_tail got start=%b data=%h want 1 %h", tx_start, tx_data, 8'(8'h68 + i)); end
      tx_done_tick = 1;
      tick();
      tx_done_tick = 0;
    end
    checks++; if (empty !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL wrap_empty got empty=%b count=%0d want 1 0", empty, count); end
  endtask

  task automatic test_flow_control();
    do_reset();
    tx_enable = 1;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1; wr_data = 8'(8'h50 + i);
      tick();
    end
    wr_en = 0;
    tx_enable = 0;
    checks++; if (tx_busy !== 1'b1 || tx_data !== 8'h50 || count !== 5'd2) begin errors++; $display("FAIL flow_setup got busy=%b data=%h count=%0d want 1 50 2", tx_busy, tx_data, count); end
    tick();
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL flow_no_abort got %b want 1", tx_busy); end
    tx_done_tick = 1;
    tick();
    tx_done_tick = 0;
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL flow_done got %b want 0", tx_busy); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (tx_start !== 1'b0 || count !== 5'd2) begin errors++; $display("FAIL flow_hold got start=%b count=%0d want 0 2", tx_start, count); end
    end
    tx_enable = 1;
    tick();
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'h51) begin errors++; $display("FAIL flow_resume got start=%b data=%h want 1 51", tx_start, tx_data); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tx_enable = 1;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1; wr_data = 8'(8'h70 + i);
      tick();
    end
    wr_en = 0;
    checks++; if (count !== 5'd5 || tx_busy !== 1'b1) begin errors++; $display("FAIL rmid_setup got count=%0d busy=%b want 5 1", count, tx_busy); end
    #2 reset = 1;
    #1;
    checks++; if (count !== 5'd0 || tx_busy !== 1'b0 || tx_start !== 1'b0 || tx_data !== 8'h00 || empty !== 1'b1) begin
      errors++; $display("FAIL rmid_async got count=%0d busy=%b start=%b data=%h empty=%b want 0 0 0 00 1", count, tx_busy, tx_start, tx_data, empty);
    end
    #1 reset = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (tx_start !== 1'b0 || tx_busy !== 1'b0) begin errors++; $display("FAIL rmid_quiet got start=%b busy=%b want 0 0", tx_start, tx_busy); end
    end
    wr_en = 1; wr_data = 8'h99;
    tick();
    wr_en = 0;
    tick();
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'h99) begin errors++; $display("FAIL rmid_new got start=%b data=%h want 1 99", tx_start, tx_data); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_overflow();
    test_wrap();
    test_flow_control();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
